// File: rtl/eth_rx_mac_filter.sv
// rtl/eth_rx_mac_filter.sv - RX destination-address frame filter with pass/drop counters
module eth_rx_mac_filter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [47:0]            mac_addr,
  input  logic                   promisc,
  input  logic                   accept_broadcast,
  input  logic                   accept_multicast,
  input  logic [63:0]            s_axis_tdata,
  input  logic [7:0]             s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [63:0]            m_axis_tdata,
  output logic [7:0]             m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [COUNT_WIDTH-1:0] frames_passed,
  output logic [COUNT_WIDTH-1:0] frames_dropped
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t      state;
  state_t      state_next;
  logic [47:0] dst;
  logic        in_hs;
  logic        is_bcast;
  logic        is_mcast;
  logic        is_runt;
  logic        addr_ok;
  logic        first_pass;
  logic        first_beat;
  logic        pass_beat;
  logic        drop_frame;

  // First octet on the wire lives in the low byte of tdata.
  assign dst = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};

  assign is_bcast   = (s_axis_tdata[47:0] == 48'hffff_ffff_ffff);
  assign is_mcast   = s_axis_tdata[0];
  assign is_runt    = s_axis_tlast && (s_axis_tkeep[5:0] != 6'h3f);
  assign addr_ok    = (dst == mac_addr) || (is_bcast && accept_broadcast) ||
                      (is_mcast && !is_bcast && accept_multicast);
  assign first_pass = promisc || (!is_runt && addr_ok);

  // DROP never needs the output slot, so it drains regardless of backpressure.
  assign s_axis_tready = (state == DROP) || !m_axis_tvalid || m_axis_tready;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign first_beat    = in_hs && (state == IDLE);
  assign pass_beat     = (first_beat && first_pass) || (in_hs && (state == PASS));
  assign drop_frame    = first_beat && !first_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_hs && !s_axis_tlast) begin
          state_next = first_pass ? PASS : DROP;
        end
      end
      PASS, DROP: begin
        if (in_hs && s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (pass_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frames_passed  <= '0;
      frames_dropped <= '0;
    end else begin
      if (pass_beat && s_axis_tlast) begin
        frames_passed <= frames_passed + 1'b1;
      end
      if (drop_frame) begin
        frames_dropped <= frames_dropped + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// tb/tb_eth_rx_mac_filter.sv - directed and mixed-frame bench for eth_rx_mac_filter
module tb_eth_rx_mac_filter;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] mac_addr;
  logic        promisc, accept_broadcast, accept_multicast;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [31:0] frames_passed, frames_dropped;

  logic [63:0] s2_tdata;
  logic [7:0]  s2_tkeep;
  logic        s2_tvalid, s2_tready, s2_tlast, s2_tuser;
  logic [63:0] m2_tdata;
  logic [7:0]  m2_tkeep;
  logic        m2_tvalid, m2_tlast, m2_tuser;
  logic [1:0]  fp2, fd2;

  always #5 clock = ~clock;

  eth_rx_mac_filter dut (
    .clock(clock), .reset(reset), .mac_addr(mac_addr), .promisc(promisc),
    .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frames_passed(frames_passed), .frames_dropped(frames_dropped)
  );

  eth_rx_mac_filter #(.COUNT_WIDTH(2)) dut_w2 (
    .clock(clock), .reset(reset), .mac_addr(mac_addr), .promisc(promisc),
    .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
    .s_axis_tdata(s2_tdata), .s_axis_tkeep(s2_tkeep), .s_axis_tvalid(s2_tvalid),
    .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast), .s_axis_tuser(s2_tuser),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
    .frames_passed(fp2), .frames_dropped(fd2)
  );

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  logic [73:0] exp_q[$];
  logic [31:0] exp_passed = 0;
  logic [31:0] exp_dropped = 0;

  localparam logic [47:0] STATION  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] W_MATCH  = 48'h01_00_00_00_00_02;
  localparam logic [47:0] W_OTHER  = 48'h03_00_00_00_00_02;
  localparam logic [47:0] W_BCAST  = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] W_MCAST  = 48'h01_00_00_5e_00_01;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (ready_mode == 2) m_axis_tready = ($urandom_range(0, 3) != 0);
    else                 m_axis_tready = (ready_mode == 1);
  end

  always @(negedge clock) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", m_axis_tvalid, 1'b0);
      end else begin
        check("out_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u,
                      input bit pass, output int stalls);
    if (pass) exp_q.push_back({d, k, l, u});
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tvalid = 1'b1;
    stalls = 0;
    @(negedge clock);
    while (!s_axis_tready && stalls < 500) begin
      stalls++;
      @(negedge clock);
    end
    if (!s_axis_tready) check("in_timeout", s_axis_tready, 1'b1);
    @(posedge clock);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dw, input int nb, input logic [7:0] lkeep,
                            input logic user, input bit pass, output int stalls_total);
    int st;
    stalls_total = 0;
    for (int i = 0; i < nb; i++) begin
      logic [63:0] d;
      d = (i == 0) ? {16'($urandom), dw} : {$urandom, $urandom};
      beat(d, (i == nb - 1) ? lkeep : 8'hff, i == nb - 1, (i == nb - 1) ? user : 1'b0, pass, st);
      stalls_total += st;
    end
    if (pass) exp_passed++;
    else      exp_dropped++;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_passed"}, frames_passed, exp_passed);
    check({tag, "_dropped"}, frames_dropped, exp_dropped);
  endtask

  function automatic bit model_pass(input logic [47:0] dw, input logic [7:0] k, input bit last,
                                    input bit p, input bit ab, input bit am, input logic [47:0] mac);
    logic [47:0] d;
    bit bc, mc, runt;
    for (int i = 0; i < 6; i++) d[47 - 8*i -: 8] = dw[8*i +: 8];
    bc   = (dw == 48'hffff_ffff_ffff);
    mc   = dw[0];
    runt = last && (k[5:0] != 6'h3f);
    if (p) return 1'b1;
    if (runt) return 1'b0;
    return (d == mac) || (bc && ab) || (mc && !bc && am);
  endfunction

  initial begin
    int st;
    logic [63:0] d0;
    reset = 1'b1;
    mac_addr = STATION; promisc = 0; accept_broadcast = 0; accept_multicast = 0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    s2_tdata = '0; s2_tkeep = '0; s2_tvalid = 0; s2_tlast = 0; s2_tuser = 0;
    m_axis_tready = 1'b1;
    #23;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_passed", frames_passed, 32'h0);
    check("rst_dropped", frames_dropped, 32'h0);
    reset = 1'b0;
    idle(2);

    // unicast match, latency 1
    d0 = {16'h1234, W_MATCH};
    beat(d0, 8'hff, 1'b0, 1'b0, 1'b1, st);
    check("uc_lat_valid", m_axis_tvalid, 1'b1);
    check("uc_lat_data", m_axis_tdata, d0);
    beat(64'hdead_beef_0000_0001, 8'hff, 1'b0, 1'b0, 1'b1, st);
    beat(64'h0000_0000_cafe_f00d, 8'h0f, 1'b1, 1'b1, 1'b1, st);
    exp_passed++;
    check_counts("uc");

    // unicast mismatch under full backpressure: drop must not stall
    idle(3);
    ready_mode = 0;
    idle(3);
    send_frame(W_OTHER, 3, 8'hff, 1'b0, 1'b0, st);
    check("mis_stalls", st, 0);
    check("mis_no_out", m_axis_tvalid, 1'b0);
    check_counts("mis");
    ready_mode = 1;
    idle(2);

    // broadcast / multicast gating
    accept_multicast = 1;
    send_frame(W_BCAST, 2, 8'hff, 1'b0, 1'b0, st);
    check_counts("bc_off");
    accept_multicast = 0; accept_broadcast = 1;
    send_frame(W_BCAST, 2, 8'h3f, 1'b0, 1'b1, st);
    check_counts("bc_on");
    send_frame(W_MCAST, 2, 8'hff, 1'b0, 1'b0, st);
    check_counts("mc_off");
    accept_multicast = 1;
    send_frame(W_MCAST, 3, 8'h01, 1'b1, 1'b1, st);
    check_counts("mc_on");
    accept_broadcast = 0; accept_multicast = 0;

    // runts
    send_frame(W_MATCH, 1, 8'h0f, 1'b0, 1'b0, st);
    check_counts("runt_drop");
    promisc = 1;
    send_frame(W_OTHER, 1, 8'h0f, 1'b0, 1'b1, st);
    check_counts("runt_promisc");
    promisc = 0;
    send_frame(W_MATCH, 1, 8'h3f, 1'b0, 1'b1, st);
    check_counts("six_byte");

    // promisc toggled mid-frame
    promisc = 1;
    beat({16'h0, W_OTHER}, 8'hff, 1'b0, 1'b0, 1'b1, st);
    promisc = 0;
    beat(64'h11, 8'hff, 1'b0, 1'b0, 1'b1, st);
    beat(64'h22, 8'hff, 1'b1, 1'b0, 1'b1, st);
    exp_passed++;
    check_counts("tog_pass");
    beat({16'h0, W_OTHER}, 8'hff, 1'b0, 1'b0, 1'b0, st);
    promisc = 1;
    beat(64'h33, 8'hff, 1'b0, 1'b0, 1'b0, st);
    beat(64'h44, 8'hff, 1'b1, 1'b0, 1'b0, st);
    promisc = 0;
    exp_dropped++;
    check_counts("tog_drop");

    // mixed frames with random backpressure
    ready_mode = 2;
    for (int f = 0; f < 100; f++) begin
      logic [47:0] dw;
      logic [7:0]  lk;
      int nb;
      bit p;
      case ($urandom_range(0, 3))
        0: dw = W_MATCH;
        1: dw = W_BCAST;
        2: dw = W_MCAST;
        default: dw = {$urandom, 16'($urandom)} & ~48'h1;
      endcase
      case ($urandom_range(0, 4))
        0: lk = 8'hff;
        1: lk = 8'h3f;
        2: lk = 8'h0f;
        3: lk = 8'h01;
        default: lk = 8'h7f;
      endcase
      nb = $urandom_range(1, 4);
      promisc = ($urandom_range(0, 4) == 0);
      accept_broadcast = $urandom_range(0, 1);
      accept_multicast = $urandom_range(0, 1);
      p = model_pass(dw, (nb == 1) ? lk : 8'hff, nb == 1, promisc, accept_broadcast,
                     accept_multicast, mac_addr);
      send_frame(dw, nb, lk, 1'($urandom_range(0, 1)), p, st);
    end
    promisc = 0; accept_broadcast = 0; accept_multicast = 0;
    ready_mode = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    check("mix_drain", exp_q.size(), 0);
    check_counts("mix");

    // reset in the middle of a passed frame
    ready_mode = 0;
    idle(3);
    beat({16'h5555, W_MATCH}, 8'hff, 1'b0, 1'b0, 1'b1, st);
    check("mid_held", m_axis_tvalid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", m_axis_tvalid, 1'b0);
    exp_q.delete();
    exp_passed = 0;
    exp_dropped = 0;
    check_counts("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    ready_mode = 1;
    idle(2);
    send_frame(W_MATCH, 2, 8'hff, 1'b0, 1'b1, st);
    idle(3);
    check("post_rst_drain", exp_q.size(), 0);
    check_counts("post_rst");

    // counter wrap with COUNT_WIDTH = 2
    s2_tdata = {16'h0, W_OTHER}; s2_tkeep = 8'hff; s2_tlast = 1'b1; s2_tvalid = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    s2_tvalid = 1'b0;
    idle(1);
    check("wrap_dropped", fd2, 2'd1);
    check("wrap_passed", fp2, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
